clk_en_gen: RTL and testbench
=============================

Name: clk_en_gen

Overview:
- Parametrised successor to the fixed four-output PLL wrapper.
- Generates NUM_CH independent fractional clock-enable pulse trains from one master clock. Each train averages f_refclk*num/den and has a programmable start phase.
- Ratios are reprogrammable at runtime; a lock/settle sequencer gates all enables and reports `locked`.
- Sits directly after the system PLL, so one fast clock domain replaces several derived clocks (video pixel CE, CPU CE, audio CE).

Parameters:
- NUM_CH, 4, number of clock-enable channels (1..16).
- ACC_W, 16, width of num, den, phase and accumulator per channel.
- LOCK_CYCLES, 16, refclk cycles spent in SETTLE before `locked` asserts (>=1).

Ports:
- refclk, in, 1, master clock; all logic is on its rising edge.
- rst, in, 1, reset; asynchronous assert, active-low (0 = reset), synchronous deassert handled upstream.
- cfg_num, in, NUM_CH*ACC_W, per-channel numerator; channel i is bits [i*ACC_W +: ACC_W].
- cfg_den, in, NUM_CH*ACC_W, per-channel denominator, same packing.
- cfg_phase, in, NUM_CH*ACC_W, per-channel initial accumulator value, same packing.
- cfg_load, in, 1, single-cycle strobe: capture cfg_* and relock.
- ce, out, NUM_CH, registered one-cycle enable pulses, bit i = channel i.
- locked, out, 1, high while enables are running on a stable configuration.

Behaviour:
- Reset (rst=0): state=LOAD, all acc=0, all captured num/den=0, ce=0, locked=0, settle counter=0.
- FSM states:
  - LOAD: one cycle; captures cfg_num/den/phase into internal registers and initialises acc_i = min(phase_i, den_i-1), or 0 if den_i==0. Then go to SETTLE.
  - SETTLE: counts LOCK_CYCLES cycles, with ce=0 and locked=0. Then go to RUN.
  - RUN: locked=1; channels accumulate.
- First cycle after rst deasserts is LOAD, so the cfg_* values present then are the power-up configuration.
- cfg_load=1 in any state: next state is LOAD, and locked and ce drop to 0 on the next edge. A cfg_load during SETTLE restarts the settle count; there is no queueing.
- Accumulation, per channel per RUN cycle:
  - sum = acc + num, evaluated at ACC_W+1 bits.
  - If sum >= den: acc <= sum - den and ce_i <= 1. Otherwise acc <= sum and ce_i <= 0.
- Channel boundary cases:
  - num==0 or den==0: channel disabled; ce_i held 0 and acc held.
  - num>=den: ce_i=1 every RUN cycle and acc held.
  - Invariant acc<den always holds, so there is no overflow at ACC_W+1 bits.
- Latency and timing:
  - locked rises on the same edge the FSM enters RUN.
  - The first possible ce pulse appears one cycle after that edge, because ce is registered from the first RUN accumulation.
  - The first pulse comes after ceil((den-phase)/num) RUN cycles.
- Leaving RUN (cfg_load or rst) clears ce on the next edge (asynchronously for rst); no partial pulse.
- Channels are independent. Identical configurations produce bit-identical, phase-aligned ce trains.

Decomposition:
- Shared package clk_en_pkg:
  - state enum {LOAD, SETTLE, RUN};
  - default ACC_W;
  - settle-counter width function ($clog2(LOCK_CYCLES+1)).
- Sub-module clk_en_ch:
  - one channel's accumulator, enable/disable logic and ce register;
  - ports refclk, rst, init, run, num, den, phase, ce;
  - instantiated NUM_CH times by a generate loop.
- Top level holds the FSM, settle counter, cfg capture and `locked`.

Test Plan:
- Reset release with ch0 num=1, den=4, phase=0 -> locked=1 after 1+16 cycles; ch0 ce pulses on RUN cycles 4, 8, 12, … (period 4, 25% duty).
- ch1 num=12, den=25, phase=0 -> exactly 48 pulses in every 100-cycle window (50 MHz→24 MHz); gaps only 2 or 3 cycles.
- ch2 num=1, den=4, phase=3 vs ch0 phase=0 -> ch2's first pulse on RUN cycle 1, then every 4 cycles, leading ch0 by 3 cycles; ch3 den=0 -> ce[3] never asserts.
- cfg_load in RUN, changing ch0 to num=1, den=2 -> ce=0 and locked=0 on the next edge; locked returns 17 cycles later; ce[0] toggles every 2 cycles.
- cfg_load pulsed again 5 cycles into SETTLE -> settle restarts; locked rises 17 cycles after the second strobe, not the first.
- rst asserted mid-RUN with ce[1]=1 -> ce and locked go 0 immediately (asynchronously); after release, the LOAD→SETTLE→RUN sequence repeats with the cfg_* values present then. Also num=5, den=3 -> ce held 1 every RUN cycle.

Source files
------------

// File: rtl/clk_en_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
package clk_en_pkg;

  localparam int DEFAULT_ACC_W = 16;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  function automatic int settle_cnt_w(input int lock_cycles);
    return $clog2(lock_cycles + 1);
  endfunction

endpackage

// File: rtl/clk_en_ch.sv
// One fractional clock-enable channel: phase accumulator with modulo-den wrap.
module clk_en_ch
  import clk_en_pkg::*;
#(
  parameter int ACC_W = DEFAULT_ACC_W
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             init,
  input  logic             run,
  input  logic [ACC_W-1:0] num,
  input  logic [ACC_W-1:0] den,
  input  logic [ACC_W-1:0] phase,
  output logic             ce
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_init;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W:0]   sum;
  logic             ce_next;

  // acc < den is kept as an invariant, so the start phase is clamped to den-1.
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, num};
    acc_next = acc;
    ce_next  = 1'b0;
    if (den == '0) begin
      acc_init = '0;
    end else if (phase >= den) begin
      acc_init = den - ACC_W'(1);
    end else begin
      acc_init = phase;
    end
    if ((num != '0) && (den != '0)) begin
      if (num >= den) begin
        ce_next = 1'b1;
      end else if (sum >= {1'b0, den}) begin
        acc_next = ACC_W'(sum - {1'b0, den});
        ce_next  = 1'b1;
      end else begin
        acc_next = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      ce  <= 1'b0;
    end else if (init) begin
      acc <= acc_init;
      ce  <= 1'b0;
    end else if (run) begin
      acc <= acc_next;
      ce  <= ce_next;
    end else begin
      ce  <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator with load/settle/run sequencing.
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ACC_W       = DEFAULT_ACC_W,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic [NUM_CH*ACC_W-1:0] cfg_num,
  input  logic [NUM_CH*ACC_W-1:0] cfg_den,
  input  logic [NUM_CH*ACC_W-1:0] cfg_phase,
  input  logic                    cfg_load,
  output logic [NUM_CH-1:0]       ce,
  output logic                    locked
);

  localparam int CW = settle_cnt_w(LOCK_CYCLES);

  state_t                  state;
  logic [CW-1:0]           settle_cnt;
  logic [NUM_CH*ACC_W-1:0] num_q;
  logic [NUM_CH*ACC_W-1:0] den_q;
  logic                    in_load;
  logic                    run_en;

  assign in_load = (state == ST_LOAD);
  assign run_en  = (state == ST_RUN) && !cfg_load;

  // A cfg_load strobe overrides every state, so it also restarts a settle in progress.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state      <= ST_LOAD;
      settle_cnt <= '0;
      locked     <= 1'b0;
      num_q      <= '0;
      den_q      <= '0;
    end else begin
      if (in_load) begin
        num_q <= cfg_num;
        den_q <= cfg_den;
      end
      if (cfg_load) begin
        state      <= ST_LOAD;
        settle_cnt <= '0;
        locked     <= 1'b0;
      end else begin
        unique case (state)
          ST_LOAD: begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            locked     <= 1'b0;
          end
          ST_SETTLE: begin
            if (settle_cnt == CW'(LOCK_CYCLES - 1)) begin
              state      <= ST_RUN;
              settle_cnt <= '0;
              locked     <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt + CW'(1);
            end
          end
          ST_RUN: begin
            locked <= 1'b1;
          end
          default: begin
            state  <= ST_LOAD;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // During LOAD the channel clamps its phase against the incoming den, not the stale one.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_W-1:0] den_sel;
    assign den_sel = in_load ? cfg_den[i*ACC_W +: ACC_W] : den_q[i*ACC_W +: ACC_W];

    clk_en_ch #(
      .ACC_W(ACC_W)
    ) u_ch (
      .refclk(refclk),
      .rst   (rst),
      .init  (in_load),
      .run   (run_en),
      .num   (num_q[i*ACC_W +: ACC_W]),
      .den   (den_sel),
      .phase (cfg_phase[i*ACC_W +: ACC_W]),
      .ce    (ce[i])
    );
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen: lock sequencing, fractional ratios, reload and reset.
module tb_clk_en_gen;

  localparam int NUM_CH = 4;
  localparam int ACC_W  = 16;
  localparam int LOCK   = 16;

  logic                    refclk;
  logic                    rst;
  logic [NUM_CH*ACC_W-1:0] cfg_num;
  logic [NUM_CH*ACC_W-1:0] cfg_den;
  logic [NUM_CH*ACC_W-1:0] cfg_phase;
  logic                    cfg_load;
  logic [NUM_CH-1:0]       ce;
  logic                    locked;

  int errors = 0;
  int checks = 0;

  int m_acc [NUM_CH];
  int m_num [NUM_CH];
  int m_den [NUM_CH];

  logic [4:0]        sb_q [$];
  logic [NUM_CH-1:0] hist [$];

  clk_en_gen #(
    .NUM_CH     (NUM_CH),
    .ACC_W      (ACC_W),
    .LOCK_CYCLES(LOCK)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_num  (cfg_num),
    .cfg_den  (cfg_den),
    .cfg_phase(cfg_phase),
    .cfg_load (cfg_load),
    .ce       (ce),
    .locked   (locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic set_ch(input int ch, input int n, input int d, input int p);
    cfg_num[ch*ACC_W +: ACC_W]   = ACC_W'(n);
    cfg_den[ch*ACC_W +: ACC_W]   = ACC_W'(d);
    cfg_phase[ch*ACC_W +: ACC_W] = ACC_W'(p);
  endtask

  // Reference model of the accumulation rule, seeded from the cfg present at LOAD.
  task automatic model_init();
    for (int i = 0; i < NUM_CH; i++) begin
      m_num[i] = int'(cfg_num[i*ACC_W +: ACC_W]);
      m_den[i] = int'(cfg_den[i*ACC_W +: ACC_W]);
      if (m_den[i] == 0)
        m_acc[i] = 0;
      else if (int'(cfg_phase[i*ACC_W +: ACC_W]) >= m_den[i])
        m_acc[i] = m_den[i] - 1;
      else
        m_acc[i] = int'(cfg_phase[i*ACC_W +: ACC_W]);
    end
  endtask

  function automatic logic [NUM_CH-1:0] model_step();
    logic [NUM_CH-1:0] r;
    int s;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_num[i] == 0 || m_den[i] == 0) begin
        r[i] = 1'b0;
      end else if (m_num[i] >= m_den[i]) begin
        r[i] = 1'b1;
      end else begin
        s = m_acc[i] + m_num[i];
        if (s >= m_den[i]) begin
          m_acc[i] = s - m_den[i];
          r[i] = 1'b1;
        end else begin
          m_acc[i] = s;
        end
      end
    end
    return r;
  endfunction

  task automatic wait_lock(input int edges, input string name);
    for (int k = 1; k <= edges; k++) begin
      step();
      checks++;
      if (k < edges) begin
        if ({locked, ce} !== 5'b0) begin
          errors++;
          $display("[TB] FAIL %s edge %0d: locked=%b ce=%b, required locked=0 ce=0", name, k, locked, ce);
        end
      end else begin
        if ({locked, ce} !== 5'b10000) begin
          errors++;
          $display("[TB] FAIL %s edge %0d: locked=%b ce=%b, required locked=1 ce=0", name, k, locked, ce);
        end
      end
    end
  endtask

  task automatic run_scoreboard(input int cycles, input string name);
    logic [4:0] exp_v;
    logic [4:0] got;
    hist.delete();
    for (int n = 1; n <= cycles; n++) begin
      sb_q.push_back({1'b1, model_step()});
      step();
      got   = {locked, ce};
      exp_v = sb_q.pop_front();
      hist.push_back(ce);
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("[TB] FAIL %s run cycle %0d: {locked,ce}=%b, required %b", name, n, got, exp_v);
      end
    end
  endtask

  task automatic pulse_load(input string name);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    checks++;
    if ({locked, ce} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL %s strobe edge: locked=%b ce=%b, required 0/0", name, locked, ce);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    cfg_load = 1'b0;
    cfg_num  = '0;
    cfg_den  = '0;
    cfg_phase = '0;
    set_ch(0, 1, 4, 0);
    set_ch(1, 12, 25, 0);
    set_ch(2, 1, 4, 3);
    set_ch(3, 1, 0, 0);
    step();
    step();
    checks++;
    if ({locked, ce} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: locked=%b ce=%b, required 0/0", locked, ce);
    end
    rst = 1'b1;
    wait_lock(1 + LOCK, "reset_lock");
  endtask

  task automatic test_ratios();
    int cnt;
    int bad0, bad2, bad3, badgap;
    int last;
    model_init();
    run_scoreboard(200, "ratios");
    bad0 = 0; bad2 = 0; bad3 = 0; badgap = 0;
    for (int i = 0; i < 200; i++) begin
      if (hist[i][0] !== (((i + 1) % 4) == 0)) bad0++;
      if (hist[i][2] !== (((i + 1) % 4) == 1)) bad2++;
      if (hist[i][3] !== 1'b0) bad3++;
    end
    checks++;
    if (bad0 != 0) begin
      errors++;
      $display("[TB] FAIL ch0_period4: %0d cycles off pattern, required 0", bad0);
    end
    checks++;
    if (bad2 != 0) begin
      errors++;
      $display("[TB] FAIL ch2_phase3: %0d cycles off pattern, required 0", bad2);
    end
    checks++;
    if (bad3 != 0) begin
      errors++;
      $display("[TB] FAIL ch3_den0: %0d pulses, required 0", bad3);
    end
    for (int w = 0; w <= 100; w += 37) begin
      cnt = 0;
      for (int i = w; i < w + 100; i++) if (hist[i][1] === 1'b1) cnt++;
      checks++;
      if (cnt != 48) begin
        errors++;
        $display("[TB] FAIL ch1_window_%0d: %0d pulses, required 48", w, cnt);
      end
    end
    last = -1;
    for (int i = 0; i < 200; i++) begin
      if (hist[i][1] === 1'b1) begin
        if (last >= 0 && (i - last) != 2 && (i - last) != 3) badgap++;
        last = i;
      end
    end
    checks++;
    if (badgap != 0) begin
      errors++;
      $display("[TB] FAIL ch1_gaps: %0d gaps outside 2..3, required 0", badgap);
    end
  endtask

  task automatic test_reload();
    int bad;
    set_ch(0, 1, 2, 0);
    pulse_load("reload");
    wait_lock(LOCK + 1, "reload_lock");
    model_init();
    run_scoreboard(40, "reload_run");
    bad = 0;
    for (int i = 0; i < 40; i++) if (hist[i][0] !== (((i + 1) % 2) == 0)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL ch0_toggle2: %0d cycles off pattern, required 0", bad);
    end
  endtask

  task automatic test_settle_restart();
    pulse_load("restart_first");
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (locked !== 1'b0) begin
        errors++;
        $display("[TB] FAIL restart_settle edge %0d: locked=%b, required 0", k, locked);
      end
    end
    pulse_load("restart_second");
    wait_lock(LOCK + 1, "restart_lock");
    model_init();
    run_scoreboard(12, "restart_run");
  endtask

  task automatic test_async_reset();
    int waited;
    waited = 0;
    while (ce[1] !== 1'b1 && waited < 50) begin
      step();
      waited++;
    end
    checks++;
    if (ce[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wait_ce1: ce[1]=%b after %0d cycles, required 1", ce[1], waited);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({locked, ce} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: locked=%b ce=%b, required 0/0 before any edge", locked, ce);
    end
    set_ch(0, 5, 3, 0);
    step();
    step();
    rst = 1'b1;
    wait_lock(1 + LOCK, "post_reset_lock");
    model_init();
    run_scoreboard(20, "post_reset_run");
    checks++;
    if (hist[0][0] !== 1'b1 || hist[19][0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ch0_num_ge_den: ce[0] first=%b last=%b, required 1/1", hist[0][0], hist[19][0]);
    end
  endtask

  initial begin
    test_reset();
    test_ratios();
    test_reload();
    test_settle_restart();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
